ip_rx_header_parser: RTL and testbench

- Receive-direction counterpart of the transmit-side IP header path (Ethernet to FPGA).
- Consumes an 8-bit AXI-Stream IPv4 packet whose Ethernet header is already stripped.
- Parses and validates the IPv4 header, presents the fields on a valid/ready header channel with the same field set as the TX header interface, then forwards the payload as an 8-bit stream.
- Sits between the Ethernet frame receiver and the UDP/ICMP demux.

---
 rtl/ip_rx_header_parser_pkg.sv | 24 ++
 rtl/ip_checksum_acc.sv | 31 +++
 rtl/ip_rx_header_parser.sv | 194 +++++++++++++++++++
 tb/tb_ip_rx_header_parser.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ip_rx_header_parser_pkg.sv
// ip_pkg: shared constants and state type for the IPv4 receive header path.
//   IP_VERSION / IP_MIN_IHL : accepted version and minimum header length (words)
//   OFS_*                   : byte offsets of captured header fields
//   HDR_CNT_MAX             : header byte counter ceiling (IHL=15 -> 60 bytes)
//   state_e                 : parser states
package ip_pkg;
  localparam logic [3:0] IP_VERSION  = 4'd4;
  localparam logic [3:0] IP_MIN_IHL  = 4'd5;
  localparam logic [5:0] OFS_TOS     = 6'd1;
  localparam logic [5:0] OFS_LEN     = 6'd2;
  localparam logic [5:0] OFS_TTL     = 6'd8;
  localparam logic [5:0] OFS_PROTO   = 6'd9;
  localparam logic [5:0] OFS_SRC     = 6'd12;
  localparam logic [5:0] OFS_DST     = 6'd16;
  localparam logic [5:0] HDR_CNT_MAX = 6'd60;

  typedef enum logic [2:0] {
    HDR,
    HDR_WAIT,
    PAYLOAD,
    DRAIN,
    DROP
  } state_e;
endpackage

// File: rtl/ip_checksum_acc.sv
// ip_checksum_acc: one's-complement header checksum accumulator.
//   clk, rst_n : clock, asynchronous active-low reset
//   start_i    : discard the running sum (first word of a new header)
//   en_i       : add word_i this cycle
//   word_i     : 16-bit word (or byte placed in its word lane)
//   match_o    : folded sum including this cycle's word equals 16'hFFFF
module ip_checksum_acc (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_i,
  input  logic        en_i,
  input  logic [15:0] word_i,
  output logic        match_o
);
  logic [19:0] acc_q, acc_d;
  logic [16:0] fold1;
  logic [15:0] fold2;

  always_comb begin
    acc_d = (start_i ? '0 : acc_q) + (en_i ? {4'd0, word_i} : '0);
    // Two folds suffice: after the first the carry is at most 1.
    fold1   = {1'b0, acc_d[15:0]} + {13'd0, acc_d[19:16]};
    fold2   = fold1[15:0] + {15'd0, fold1[16]};
    match_o = (fold2 == 16'hFFFF);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) acc_q <= '0;
    else        acc_q <= acc_d;
  end
endmodule

// File: rtl/ip_rx_header_parser.sv
// ip_rx_header_parser: parses/validates an IPv4 header from an 8-bit stream,
// presents fields on a valid/ready header channel, then passes the payload.
//   s_axis_*   : input packet stream (Ethernet header already removed)
//   hdr_*      : header handshake; dscp/ecn/length/ttl/protocol/source_ip/dest_ip
//   m_axis_*   : payload stream; tuser on the tlast beat flags truncation
//   drop_count : saturating count of discarded packets
module ip_rx_header_parser
  import ip_pkg::*;
#(
  parameter bit CHECK_CHECKSUM = 1'b1,
  parameter bit ACCEPT_OPTIONS = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  s_axis_tdata,
  input  logic        s_axis_tvalid,
  output logic        s_axis_tready,
  input  logic        s_axis_tlast,
  output logic        hdr_valid,
  input  logic        hdr_ready,
  output logic [5:0]  dscp,
  output logic [1:0]  ecn,
  output logic [15:0] length,
  output logic [7:0]  ttl,
  output logic [7:0]  protocol,
  output logic [31:0] source_ip,
  output logic [31:0] dest_ip,
  output logic [7:0]  m_axis_tdata,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic        m_axis_tlast,
  output logic        m_axis_tuser,
  output logic [15:0] drop_count
);
  state_e      state_q, state_d;
  logic        run_q;
  logic [5:0]  cnt_q, cnt_d;
  logic [3:0]  ihl_q, ihl_d;
  logic [7:0]  tos_q, tos_d, ttl_q, ttl_d, proto_q, proto_d;
  logic [15:0] tot_len_q, tot_len_d, length_q, length_d, rem_q, rem_d;
  logic [15:0] drop_cnt_q, drop_cnt_d;
  logic [31:0] src_q, src_d, dst_q, dst_d;
  logic        hdr_valid_q, hdr_valid_d;
  logic        drop_inc;

  logic [5:0]  hdr_len;
  logic        hdr_last, bad_first, s_fire, m_fire, in_pay, csum_ok;

  assign hdr_len  = {ihl_q, 2'b00};
  assign hdr_last = (cnt_q != '0) && (cnt_q == hdr_len - 6'd1);
  assign bad_first = (s_axis_tdata[7:4] != IP_VERSION) || (s_axis_tdata[3:0] < IP_MIN_IHL) ||
                     (!ACCEPT_OPTIONS && (s_axis_tdata[3:0] != IP_MIN_IHL));

  // run_q keeps tready low while reset is asserted so every output reads 0.
  always_comb begin
    unique case (state_q)
      HDR, DRAIN, DROP: s_axis_tready = run_q;
      PAYLOAD:          s_axis_tready = m_axis_tready;
      default:          s_axis_tready = 1'b0;
    endcase
  end

  assign s_fire        = s_axis_tvalid & s_axis_tready;
  assign in_pay        = (state_q == PAYLOAD);
  assign m_axis_tvalid = in_pay & s_axis_tvalid;
  assign m_axis_tdata  = in_pay ? s_axis_tdata : '0;
  assign m_axis_tlast  = in_pay & ((rem_q == 16'd1) | s_axis_tlast);
  assign m_axis_tuser  = in_pay & s_axis_tlast & (rem_q > 16'd1);
  assign m_fire        = m_axis_tvalid & m_axis_tready;

  // Even header bytes occupy the upper lane of their 16-bit word.
  ip_checksum_acc u_csum (
    .clk     (clk),
    .rst_n   (rst_n),
    .start_i (state_q == HDR && cnt_q == '0),
    .en_i    (state_q == HDR && s_fire),
    .word_i  (cnt_q[0] ? {8'd0, s_axis_tdata} : {s_axis_tdata, 8'd0}),
    .match_o (csum_ok)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ihl_d       = ihl_q;
    tos_d       = tos_q;
    ttl_d       = ttl_q;
    proto_d     = proto_q;
    tot_len_d   = tot_len_q;
    length_d    = length_q;
    rem_d       = rem_q;
    src_d       = src_q;
    dst_d       = dst_q;
    hdr_valid_d = hdr_valid_q;
    drop_inc    = 1'b0;

    unique case (state_q)
      HDR: if (s_fire) begin
        cnt_d = (cnt_q == HDR_CNT_MAX) ? cnt_q : cnt_q + 6'd1;
        case (cnt_q)
          OFS_TOS:        tos_d     = s_axis_tdata;
          OFS_LEN:        tot_len_d = {s_axis_tdata, tot_len_q[7:0]};
          OFS_LEN + 6'd1: tot_len_d = {tot_len_q[15:8], s_axis_tdata};
          OFS_TTL:        ttl_d     = s_axis_tdata;
          OFS_PROTO:      proto_d   = s_axis_tdata;
          OFS_SRC, OFS_SRC + 6'd1, OFS_SRC + 6'd2, OFS_SRC + 6'd3:
                          src_d     = {src_q[23:0], s_axis_tdata};
          OFS_DST, OFS_DST + 6'd1, OFS_DST + 6'd2, OFS_DST + 6'd3:
                          dst_d     = {dst_q[23:0], s_axis_tdata};
          default: ;
        endcase
        if (cnt_q == '0) ihl_d = s_axis_tdata[3:0];

        if (s_axis_tlast) begin
          drop_inc = 1'b1;
          cnt_d    = '0;
        end else if (cnt_q == '0) begin
          if (bad_first) begin
            drop_inc = 1'b1;
            cnt_d    = '0;
            state_d  = DROP;
          end
        end else if (hdr_last) begin
          cnt_d = '0;
          if ((CHECK_CHECKSUM && !csum_ok) || (tot_len_q < {10'd0, hdr_len})) begin
            drop_inc = 1'b1;
            state_d  = DROP;
          end else begin
            length_d    = tot_len_q - {10'd0, hdr_len};
            hdr_valid_d = 1'b1;
            state_d     = HDR_WAIT;
          end
        end
      end
      HDR_WAIT: if (hdr_ready) begin
        hdr_valid_d = 1'b0;
        rem_d       = length_q;
        state_d     = (length_q == '0) ? DRAIN : PAYLOAD;
      end
      PAYLOAD: if (m_fire) begin
        rem_d = rem_q - 16'd1;
        if (s_axis_tlast)         state_d = HDR;
        else if (rem_q == 16'd1)  state_d = DRAIN;
      end
      DRAIN, DROP: if (s_fire && s_axis_tlast) state_d = HDR;
      default: state_d = HDR;
    endcase

    drop_cnt_d = (drop_inc && drop_cnt_q != 16'hFFFF) ? drop_cnt_q + 16'd1 : drop_cnt_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= HDR;
      run_q       <= 1'b0;
      cnt_q       <= '0;
      ihl_q       <= '0;
      tos_q       <= '0;
      ttl_q       <= '0;
      proto_q     <= '0;
      tot_len_q   <= '0;
      length_q    <= '0;
      rem_q       <= '0;
      src_q       <= '0;
      dst_q       <= '0;
      hdr_valid_q <= 1'b0;
      drop_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      run_q       <= 1'b1;
      cnt_q       <= cnt_d;
      ihl_q       <= ihl_d;
      tos_q       <= tos_d;
      ttl_q       <= ttl_d;
      proto_q     <= proto_d;
      tot_len_q   <= tot_len_d;
      length_q    <= length_d;
      rem_q       <= rem_d;
      src_q       <= src_d;
      dst_q       <= dst_d;
      hdr_valid_q <= hdr_valid_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  assign hdr_valid  = hdr_valid_q;
  assign dscp       = tos_q[7:2];
  assign ecn        = tos_q[1:0];
  assign length     = length_q;
  assign ttl        = ttl_q;
  assign protocol   = proto_q;
  assign source_ip  = src_q;
  assign dest_ip    = dst_q;
  assign drop_count = drop_cnt_q;
endmodule

// File: tb/tb_ip_rx_header_parser.sv
// Scoreboard bench for ip_rx_header_parser: stimulus pushes expected headers
// and payload beats into queues; monitors pop and compare on each handshake.
module tb_ip_rx_header_parser;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  s_axis_tdata = '0;
  logic        s_axis_tvalid = 1'b0, s_axis_tlast = 1'b0, s_axis_tready;
  logic        hdr_valid, hdr_ready = 1'b0;
  logic [5:0]  dscp;
  logic [1:0]  ecn;
  logic [15:0] length, drop_count;
  logic [7:0]  ttl, protocol, m_axis_tdata;
  logic [31:0] source_ip, dest_ip;
  logic        m_axis_tvalid, m_axis_tready = 1'b1, m_axis_tlast, m_axis_tuser;

  always #5 clk = ~clk;

  ip_rx_header_parser #(.CHECK_CHECKSUM(1'b1), .ACCEPT_OPTIONS(1'b1)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast),
    .hdr_valid(hdr_valid), .hdr_ready(hdr_ready),
    .dscp(dscp), .ecn(ecn), .length(length), .ttl(ttl), .protocol(protocol),
    .source_ip(source_ip), .dest_ip(dest_ip),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
    .m_axis_tuser(m_axis_tuser), .drop_count(drop_count)
  );

  typedef struct {
    logic [5:0] dscp; logic [1:0] ecn; logic [15:0] length;
    logic [7:0] ttl; logic [7:0] protocol; logic [31:0] src; logic [31:0] dst;
  } hdr_t;
  typedef struct { logic [7:0] data; logic last; logic user; } beat_t;

  hdr_t        hq[$];
  beat_t       pq[$];
  logic [7:0]  fr[$];
  int unsigned n_checks = 0, n_pass = 0;
  int unsigned hdr_delay = 0;
  bit          rnd_ready = 1'b0;
  logic [15:0] exp_drop = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic note_fail(input string name);
    n_checks++;
    $display("FAIL %s: got event expected none at %0t", name, $time);
  endtask

  function automatic logic [15:0] csum(input int unsigned n);
    logic [31:0] s = '0;
    for (int unsigned i = 0; i < n; i += 2) s += {16'd0, fr[i], fr[i+1]};
    while (s[31:16] != '0) s = {16'd0, s[15:0]} + {16'd0, s[31:16]};
    return ~s[15:0];
  endfunction

  task automatic build_hdr(input logic [3:0] ver, input logic [3:0] ihl, input logic [7:0] tos,
                           input logic [15:0] tl, input logic [7:0] t, input logic [7:0] pr,
                           input logic [31:0] src, input logic [31:0] dst);
    logic [15:0] c;
    fr.delete();
    fr.push_back({ver, ihl}); fr.push_back(tos); fr.push_back(tl[15:8]); fr.push_back(tl[7:0]);
    repeat (4) fr.push_back(8'h00);
    fr.push_back(t); fr.push_back(pr); fr.push_back(8'h00); fr.push_back(8'h00);
    for (int i = 3; i >= 0; i--) fr.push_back(src[i*8 +: 8]);
    for (int i = 3; i >= 0; i--) fr.push_back(dst[i*8 +: 8]);
    for (int unsigned i = 5; i < ihl; i++) repeat (4) fr.push_back(8'h01);
    c = csum(fr.size());
    fr[10] = c[15:8];
    fr[11] = c[7:0];
  endtask

  task automatic push_hdr(input logic [5:0] d, input logic [1:0] e, input logic [15:0] len,
                          input logic [7:0] t, input logic [7:0] pr);
    hdr_t h;
    h.dscp = d; h.ecn = e; h.length = len; h.ttl = t; h.protocol = pr;
    h.src = 32'h0A000001; h.dst = 32'h0A000002;
    hq.push_back(h);
  endtask

  // Append n bytes base, base+1, ...; expect the first k as beats, last on beat k if lst.
  task automatic add_payload(input int unsigned n, input logic [7:0] base, input int unsigned k,
                             input bit lst, input bit usr);
    beat_t b;
    for (int unsigned i = 0; i < n; i++) fr.push_back(base + 8'(i));
    for (int unsigned i = 0; i < k; i++) begin
      b.data = base + 8'(i);
      b.last = lst && (i == k - 1);
      b.user = usr && (i == k - 1);
      pq.push_back(b);
    end
  endtask

  task automatic send_frame(input bit with_last);
    bit acc;
    int unsigned n;
    for (int unsigned i = 0; i < fr.size(); i++) begin
      s_axis_tdata  = fr[i];
      s_axis_tvalid = 1'b1;
      s_axis_tlast  = with_last && (i == fr.size() - 1);
      acc = 1'b0;
      n = 0;
      while (!acc && n < 400) begin
        @(negedge clk);
        acc = s_axis_tready;
        @(posedge clk); #1;
        n++;
      end
      if (!acc) begin
        note_fail("s_handshake_timeout");
        break;
      end
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  task automatic wait_idle();
    int unsigned n = 0;
    while ((hq.size() != 0 || pq.size() != 0) && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 500) note_fail("scoreboard_drain_timeout");
    repeat (3) @(posedge clk);
    #1;
  endtask

  // Header monitor: while hdr_valid the input must be stalled and fields held.
  initial forever begin
    @(negedge clk);
    if (rst_n && hdr_valid) begin
      chk("hdr_wait_s_tready", s_axis_tready, 0);
      if (hq.size() == 0) note_fail("unexpected_hdr");
      else begin
        chk("dscp", dscp, hq[0].dscp);
        chk("ecn", ecn, hq[0].ecn);
        chk("length", length, hq[0].length);
        chk("ttl", ttl, hq[0].ttl);
        chk("protocol", protocol, hq[0].protocol);
        chk("source_ip", source_ip, hq[0].src);
        chk("dest_ip", dest_ip, hq[0].dst);
        if (hdr_ready) void'(hq.pop_front());
      end
    end
  end

  // Payload monitor.
  initial forever begin
    beat_t b;
    @(negedge clk);
    if (rst_n && m_axis_tvalid && m_axis_tready) begin
      if (pq.size() == 0) note_fail("unexpected_beat");
      else begin
        b = pq.pop_front();
        chk("m_tdata", m_axis_tdata, b.data);
        chk("m_tlast", m_axis_tlast, b.last);
        chk("m_tuser", m_axis_tuser, b.user);
      end
    end
  end

  // Sink-side drivers: header ready after hdr_delay cycles, payload ready optionally random.
  initial begin
    int unsigned wcnt = 0;
    forever begin
      @(posedge clk); #1;
      m_axis_tready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (hdr_valid) begin
        if (wcnt >= hdr_delay) hdr_ready = 1'b1;
        else begin hdr_ready = 1'b0; wcnt++; end
      end else begin
        hdr_ready = 1'b0;
        wcnt = 0;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_hdr_valid", hdr_valid, 0);
    chk("rst_s_tready", s_axis_tready, 0);
    chk("rst_m_tvalid", m_axis_tvalid, 0);
    chk("rst_drop_count", drop_count, 0);
    chk("rst_length", length, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Valid packet, 8 payload bytes.
    build_hdr(4'd4, 4'd5, 8'hB9, 16'd28, 8'd64, 8'd17, 32'h0A000001, 32'h0A000002);
    chk("hdr_cksum_byte10", fr[10], 8'h66);
    push_hdr(6'd46, 2'd1, 16'd8, 8'd64, 8'd17);
    add_payload(8, 8'h10, 8, 1'b1, 1'b0);
    send_frame(1'b1);
    wait_idle();

    // Corrupted checksum: dropped silently, then a good packet.
    build_hdr(4'd4, 4'd5, 8'hB9, 16'd28, 8'd64, 8'd17, 32'h0A000001, 32'h0A000002);
    fr[10] = fr[10] ^ 8'hFF;
    add_payload(8, 8'h20, 0, 1'b0, 1'b0);
    send_frame(1'b1);
    wait_idle();
    exp_drop = 16'd1;
    chk("drop_count_cksum", drop_count, exp_drop);
    build_hdr(4'd4, 4'd5, 8'h04, 16'd23, 8'd7, 8'd6, 32'h0A000001, 32'h0A000002);
    push_hdr(6'd1, 2'd0, 16'd3, 8'd7, 8'd6);
    add_payload(3, 8'h30, 3, 1'b1, 1'b0);
    send_frame(1'b1);
    wait_idle();

    // Ethernet padding: 46-byte frame carrying 8 payload bytes.
    build_hdr(4'd4, 4'd5, 8'hB9, 16'd28, 8'd64, 8'd17, 32'h0A000001, 32'h0A000002);
    push_hdr(6'd46, 2'd1, 16'd8, 8'd64, 8'd17);
    add_payload(26, 8'h40, 8, 1'b1, 1'b0);
    send_frame(1'b1);
    wait_idle();

    // Truncation: total_length 100, frame ends after 10 payload bytes.
    build_hdr(4'd4, 4'd5, 8'h00, 16'd100, 8'd1, 8'd17, 32'h0A000001, 32'h0A000002);
    push_hdr(6'd0, 2'd0, 16'd80, 8'd1, 8'd17);
    add_payload(10, 8'h60, 10, 1'b1, 1'b1);
    send_frame(1'b1);
    wait_idle();

    // Backpressure on both the header and payload channels.
    hdr_delay = 5;
    rnd_ready = 1'b1;
    build_hdr(4'd4, 4'd5, 8'hFF, 16'd32, 8'd255, 8'd1, 32'h0A000001, 32'h0A000002);
    push_hdr(6'd63, 2'd3, 16'd12, 8'd255, 8'd1);
    add_payload(12, 8'h80, 12, 1'b1, 1'b0);
    send_frame(1'b1);
    wait_idle();
    hdr_delay = 0;
    rnd_ready = 1'b0;

    // IHL=6: four option bytes skipped, length = 30 - 24.
    build_hdr(4'd4, 4'd6, 8'h10, 16'd30, 8'd9, 8'd17, 32'h0A000001, 32'h0A000002);
    push_hdr(6'd4, 2'd0, 16'd6, 8'd9, 8'd17);
    add_payload(6, 8'hC0, 6, 1'b1, 1'b0);
    send_frame(1'b1);
    wait_idle();

    // Zero-length payload: header only, trailing bytes drained.
    build_hdr(4'd4, 4'd5, 8'h00, 16'd20, 8'd3, 8'd1, 32'h0A000001, 32'h0A000002);
    push_hdr(6'd0, 2'd0, 16'd0, 8'd3, 8'd1);
    add_payload(2, 8'hE0, 0, 1'b0, 1'b0);
    send_frame(1'b1);
    wait_idle();

    // Drops: bad version, tlast inside header, total_length below header size.
    build_hdr(4'd6, 4'd5, 8'h00, 16'd28, 8'd3, 8'd1, 32'h0A000001, 32'h0A000002);
    add_payload(8, 8'h00, 0, 1'b0, 1'b0);
    send_frame(1'b1);
    wait_idle();
    exp_drop = 16'd2;
    chk("drop_count_version", drop_count, exp_drop);
    build_hdr(4'd4, 4'd5, 8'h00, 16'd28, 8'd3, 8'd1, 32'h0A000001, 32'h0A000002);
    while (fr.size() > 10) void'(fr.pop_back());
    send_frame(1'b1);
    wait_idle();
    exp_drop = 16'd3;
    chk("drop_count_short", drop_count, exp_drop);
    build_hdr(4'd4, 4'd5, 8'h00, 16'd16, 8'd3, 8'd1, 32'h0A000001, 32'h0A000002);
    add_payload(4, 8'h00, 0, 1'b0, 1'b0);
    send_frame(1'b1);
    wait_idle();
    exp_drop = 16'd4;
    chk("drop_count_totlen", drop_count, exp_drop);

    // Reset in the middle of a payload, then a clean frame.
    build_hdr(4'd4, 4'd5, 8'hB9, 16'd28, 8'd64, 8'd17, 32'h0A000001, 32'h0A000002);
    push_hdr(6'd46, 2'd1, 16'd8, 8'd64, 8'd17);
    add_payload(3, 8'hA0, 3, 1'b0, 1'b0);
    send_frame(1'b0);
    wait_idle();
    rst_n = 1'b0;
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = 8'hAA;
    @(negedge clk);
    chk("mid_rst_hdr_valid", hdr_valid, 0);
    chk("mid_rst_s_tready", s_axis_tready, 0);
    chk("mid_rst_m_tvalid", m_axis_tvalid, 0);
    chk("mid_rst_m_tdata", m_axis_tdata, 0);
    chk("mid_rst_drop_count", drop_count, 0);
    chk("mid_rst_source_ip", source_ip, 0);
    chk("mid_rst_length", length, 0);
    @(posedge clk); #1;
    s_axis_tvalid = 1'b0;
    rst_n = 1'b1;
    exp_drop = 16'd0;
    build_hdr(4'd4, 4'd5, 8'hB9, 16'd28, 8'd64, 8'd17, 32'h0A000001, 32'h0A000002);
    push_hdr(6'd46, 2'd1, 16'd8, 8'd64, 8'd17);
    add_payload(8, 8'h50, 8, 1'b1, 1'b0);
    send_frame(1'b1);
    wait_idle();
    chk("drop_count_after_rst", drop_count, exp_drop);
    chk("hq_empty", hq.size(), 0);
    chk("pq_empty", pq.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
